// File: rtl/axis_demux.sv
// axis_demux: one AXI-Stream slave routed to one of two masters.
// The route is chosen by `sel` at the first beat of a packet and held until
// that packet's tlast beat is accepted. Each master output has a one-entry
// skid-free register, so a drain and a load can happen in the same cycle.
// Each output also counts the packets it has completed.
module axis_demux #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // slave side
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  sel,
  // master 0
  output logic [DATA_WIDTH-1:0] m_axis_tdata_0,
  output logic                  m_axis_tvalid_0,
  output logic                  m_axis_tlast_0,
  input  logic                  m_axis_tready_0,
  // master 1
  output logic [DATA_WIDTH-1:0] m_axis_tdata_1,
  output logic                  m_axis_tvalid_1,
  output logic                  m_axis_tlast_1,
  input  logic                  m_axis_tready_1,
  // completed-packet counters
  output logic [7:0]            pkt_cnt_0,
  output logic [7:0]            pkt_cnt_1
);

  typedef enum logic {
    ST_IDLE   = 1'b0,  // no packet open, route follows live sel
    ST_LOCKED = 1'b1   // packet open, route follows r_route
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_route;

  logic [DATA_WIDTH-1:0] r_data_0;
  logic                  r_last_0;
  logic                  r_valid_0;
  logic [DATA_WIDTH-1:0] r_data_1;
  logic                  r_last_1;
  logic                  r_valid_1;
  logic [7:0]            r_cnt_0;
  logic [7:0]            r_cnt_1;

  logic                  w_route;
  logic                  w_free_0;
  logic                  w_free_1;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_load_0;
  logic                  w_load_1;
  logic                  w_xfer_0;
  logic                  w_xfer_1;

  // Route in effect this cycle: locked route mid-packet, live sel otherwise.
  assign w_route  = (r_state == ST_LOCKED) ? r_route : sel;

  // An output register can take a new beat if empty or draining this cycle.
  assign w_free_0 = !r_valid_0 || m_axis_tready_0;
  assign w_free_1 = !r_valid_1 || m_axis_tready_1;

  // Ready looks only at the selected output; forced low while in reset.
  assign w_ready  = aresetn && (w_route ? w_free_1 : w_free_0);
  assign w_accept = s_axis_tvalid && w_ready;
  assign w_load_0 = w_accept && !w_route;
  assign w_load_1 = w_accept &&  w_route;
  assign w_xfer_0 = r_valid_0 && m_axis_tready_0;
  assign w_xfer_1 = r_valid_1 && m_axis_tready_1;

  // Route FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement or block ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Route FSM next-state: open a packet on a non-last beat, close on tlast.
  // NOTE: the default assignment first keeps this block free of latches
  // on any path that does not assign w_state_nxt explicitly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !s_axis_tlast) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept &&  s_axis_tlast) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the packet's route at its first beat (only when a packet opens).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_route <= 1'b0;
    end else if (r_state == ST_IDLE && w_accept && !s_axis_tlast) begin
      r_route <= sel;
    end
  end

  // Output 0 register: load wins over drain so back-to-back beats have no bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data_0  <= '0;
      r_last_0  <= 1'b0;
      r_valid_0 <= 1'b0;
    end else if (w_load_0) begin
      r_data_0  <= s_axis_tdata;
      r_last_0  <= s_axis_tlast;
      r_valid_0 <= 1'b1;
    end else if (w_xfer_0) begin
      r_valid_0 <= 1'b0;
    end
  end

  // Output 1 register: same behaviour as output 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data_1  <= '0;
      r_last_1  <= 1'b0;
      r_valid_1 <= 1'b0;
    end else if (w_load_1) begin
      r_data_1  <= s_axis_tdata;
      r_last_1  <= s_axis_tlast;
      r_valid_1 <= 1'b1;
    end else if (w_xfer_1) begin
      r_valid_1 <= 1'b0;
    end
  end

  // Completed-packet counters: bump on a tlast transfer, wrap naturally at 8 bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt_0 <= 8'd0;
      r_cnt_1 <= 8'd0;
    end else begin
      if (w_xfer_0 && r_last_0) r_cnt_0 <= r_cnt_0 + 8'd1;
      if (w_xfer_1 && r_last_1) r_cnt_1 <= r_cnt_1 + 8'd1;
    end
  end

  assign s_axis_tready   = w_ready;
  assign m_axis_tdata_0  = r_data_0;
  assign m_axis_tlast_0  = r_last_0;
  assign m_axis_tvalid_0 = r_valid_0;
  assign m_axis_tdata_1  = r_data_1;
  assign m_axis_tlast_1  = r_last_1;
  assign m_axis_tvalid_1 = r_valid_1;
  assign pkt_cnt_0       = r_cnt_0;
  assign pkt_cnt_1       = r_cnt_1;

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: routing, packet lock, backpressure,
// independent outputs, counter wrap and mid-packet reset.
module tb_axis_demux;

  localparam int DW = 8;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          sel;
  logic [DW-1:0] m_axis_tdata_0;
  logic          m_axis_tvalid_0;
  logic          m_axis_tlast_0;
  logic          m_axis_tready_0;
  logic [DW-1:0] m_axis_tdata_1;
  logic          m_axis_tvalid_1;
  logic          m_axis_tlast_1;
  logic          m_axis_tready_1;
  logic [7:0]    pkt_cnt_0;
  logic [7:0]    pkt_cnt_1;

  int total = 0;
  int bad   = 0;

  axis_demux #(.DATA_WIDTH(DW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .sel             (sel),
    .m_axis_tdata_0  (m_axis_tdata_0),
    .m_axis_tvalid_0 (m_axis_tvalid_0),
    .m_axis_tlast_0  (m_axis_tlast_0),
    .m_axis_tready_0 (m_axis_tready_0),
    .m_axis_tdata_1  (m_axis_tdata_1),
    .m_axis_tvalid_1 (m_axis_tvalid_1),
    .m_axis_tlast_1  (m_axis_tlast_1),
    .m_axis_tready_1 (m_axis_tready_1),
    .pkt_cnt_0       (pkt_cnt_0),
    .pkt_cnt_1       (pkt_cnt_1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Stream n single-beat packets into output 0, then let the last one drain.
  task automatic send_singles(input int n);
    sel             = 1'b0;
    m_axis_tready_0 = 1'b1;
    s_axis_tvalid   = 1'b1;
    s_axis_tlast    = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata = DW'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    aresetn         = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    sel             = 1'b0;
    m_axis_tready_0 = 1'b0;
    m_axis_tready_1 = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_tready", s_axis_tready, 0);
    check("rst_valid0", m_axis_tvalid_0, 0);
    check("rst_valid1", m_axis_tvalid_1, 0);
    check("rst_data0",  m_axis_tdata_0, 0);
    check("rst_cnt0",   pkt_cnt_0, 0);
    check("rst_cnt1",   pkt_cnt_1, 0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    // ---------------- 4-beat packet to output 0 ----------------
    sel             = 1'b0;
    m_axis_tready_0 = 1'b1;
    m_axis_tready_1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata  = 8'hA0 + DW'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 3);
      #1;
      check("p1_sready", s_axis_tready, 1);
      tick();
      check("p1_valid0", m_axis_tvalid_0, 1);
      check("p1_data0",  m_axis_tdata_0, 8'hA0 + i);
      check("p1_last0",  m_axis_tlast_0, (i == 3));
      check("p1_valid1", m_axis_tvalid_1, 0);
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("p1_drain0", m_axis_tvalid_0, 0);
    check("p1_cnt0",   pkt_cnt_0, 1);
    check("p1_cnt1",   pkt_cnt_1, 0);

    // ---------------- sel toggled mid-packet is ignored ----------------
    sel             = 1'b1;
    m_axis_tready_1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) sel = 1'b0;
      s_axis_tdata  = 8'hB0 + DW'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 2);
      tick();
      check("p2_valid1", m_axis_tvalid_1, 1);
      check("p2_data1",  m_axis_tdata_1, 8'hB0 + i);
      check("p2_valid0", m_axis_tvalid_0, 0);
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("p2_cnt1",   pkt_cnt_1, 1);
    check("p2_drain1", m_axis_tvalid_1, 0);
    // next packet follows the new sel=0
    s_axis_tdata  = 8'hC0;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    tick();
    check("p2b_valid0", m_axis_tvalid_0, 1);
    check("p2b_data0",  m_axis_tdata_0, 8'hC0);
    check("p2b_valid1", m_axis_tvalid_1, 0);
    s_axis_tvalid = 1'b0;
    tick();
    check("p2b_cnt0", pkt_cnt_0, 2);

    // ---------------- backpressure on output 0 ----------------
    m_axis_tready_0 = 1'b0;
    m_axis_tready_1 = 1'b1;
    s_axis_tdata    = 8'hD0;
    s_axis_tvalid   = 1'b1;
    s_axis_tlast    = 1'b0;
    tick();
    check("bp_valid0", m_axis_tvalid_0, 1);
    s_axis_tdata = 8'hD1;
    #1;
    check("bp_sready_a", s_axis_tready, 0);
    tick();
    check("bp_hold_a", m_axis_tdata_0, 8'hD0);
    check("bp_last_a", m_axis_tlast_0, 0);
    m_axis_tready_1 = 1'b0;
    #1;
    check("bp_sready_b", s_axis_tready, 0);
    tick();
    check("bp_hold_b", m_axis_tdata_0, 8'hD0);
    m_axis_tready_1 = 1'b1;
    #1;
    check("bp_sready_c", s_axis_tready, 0);
    m_axis_tready_0 = 1'b1;
    #1;
    check("bp_sready_d", s_axis_tready, 1);
    tick();
    check("bp_data_d1", m_axis_tdata_0, 8'hD1);
    check("bp_valid_d1", m_axis_tvalid_0, 1);
    s_axis_tdata = 8'hD2;
    s_axis_tlast = 1'b1;
    tick();
    check("bp_data_d2", m_axis_tdata_0, 8'hD2);
    check("bp_last_d2", m_axis_tlast_0, 1);
    s_axis_tvalid = 1'b0;
    tick();
    check("bp_drain0", m_axis_tvalid_0, 0);
    check("bp_cnt0",   pkt_cnt_0, 3);
    check("bp_valid1", m_axis_tvalid_1, 0);

    // ---------------- output 1 held while output 0 streams ----------------
    m_axis_tready_1 = 1'b0;
    sel             = 1'b1;
    s_axis_tdata    = 8'hE0;
    s_axis_tvalid   = 1'b1;
    s_axis_tlast    = 1'b1;
    tick();
    check("ind_valid1", m_axis_tvalid_1, 1);
    check("ind_data1",  m_axis_tdata_1, 8'hE0);
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = 8'hF0 + DW'(i);
      s_axis_tlast = (i == 2);
      #1;
      check("ind_sready", s_axis_tready, 1);
      tick();
      check("ind_data0",   m_axis_tdata_0, 8'hF0 + i);
      check("ind_valid0",  m_axis_tvalid_0, 1);
      check("ind_hold_v1", m_axis_tvalid_1, 1);
      check("ind_hold_d1", m_axis_tdata_1, 8'hE0);
      check("ind_hold_l1", m_axis_tlast_1, 1);
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("ind_cnt0", pkt_cnt_0, 4);
    check("ind_cnt1_held", pkt_cnt_1, 1);
    m_axis_tready_1 = 1'b1;
    tick();
    check("ind_drain1", m_axis_tvalid_1, 0);
    check("ind_cnt1",   pkt_cnt_1, 2);

    // ---------------- counter wrap on output 0 (starts at 4) ----------------
    send_singles(251);
    check("wrap_255", pkt_cnt_0, 255);
    send_singles(1);
    check("wrap_0", pkt_cnt_0, 0);
    send_singles(4);
    check("wrap_4", pkt_cnt_0, 4);
    check("wrap_cnt1", pkt_cnt_1, 2);

    // ---------------- reset mid-packet with both outputs pending ----------------
    m_axis_tready_0 = 1'b0;
    m_axis_tready_1 = 1'b0;
    sel             = 1'b1;
    s_axis_tdata    = 8'h51;
    s_axis_tvalid   = 1'b1;
    s_axis_tlast    = 1'b1;
    tick();
    sel          = 1'b0;
    s_axis_tdata = 8'h60;
    s_axis_tlast = 1'b0;
    tick();
    check("mr_pend0", m_axis_tvalid_0, 1);
    check("mr_pend1", m_axis_tvalid_1, 1);
    s_axis_tvalid = 1'b0;
    sel           = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check("mr_valid0", m_axis_tvalid_0, 0);
    check("mr_valid1", m_axis_tvalid_1, 0);
    check("mr_last1",  m_axis_tlast_1, 0);
    check("mr_data1",  m_axis_tdata_1, 0);
    check("mr_cnt0",   pkt_cnt_0, 0);
    check("mr_cnt1",   pkt_cnt_1, 0);
    check("mr_sready", s_axis_tready, 0);
    tick();
    aresetn         = 1'b1;
    m_axis_tready_1 = 1'b1;
    s_axis_tdata    = 8'h70;
    s_axis_tvalid   = 1'b1;
    s_axis_tlast    = 1'b0;
    tick();
    check("post_valid1", m_axis_tvalid_1, 1);
    check("post_data1",  m_axis_tdata_1, 8'h70);
    check("post_valid0", m_axis_tvalid_0, 0);
    s_axis_tdata = 8'h71;
    s_axis_tlast = 1'b1;
    tick();
    check("post_data1b", m_axis_tdata_1, 8'h71);
    s_axis_tvalid = 1'b0;
    tick();
    check("post_cnt1", pkt_cnt_1, 1);
    check("post_cnt0", pkt_cnt_0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_demux.md
AXIS_DEMUX -- requirements
Module: axis_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of every tdata port.
REQ-002 aclk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 aresetn  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 s_axis_tdata  input  DATA_WIDTH  slave beat data.
REQ-005 s_axis_tvalid  input  1  slave beat valid.
REQ-006 s_axis_tlast  input  1  slave last beat of packet.
REQ-007 s_axis_tready  output  1  slave ready.
REQ-008 sel  input  1  destination select: 0 routes to output 0, 1 routes to output 1.
REQ-009 m_axis_tdata_0 / m_axis_tdata_1  output  DATA_WIDTH  master data, per output.
REQ-010 m_axis_tvalid_0 / m_axis_tvalid_1  output  1  master valid, per output.
REQ-011 m_axis_tlast_0 / m_axis_tlast_1  output  1  master last, per output.
REQ-012 m_axis_tready_0 / m_axis_tready_1  input  1  downstream ready, per output.
REQ-013 pkt_cnt_0 / pkt_cnt_1  output  8  completed-packet count, per output.

Function
REQ-014 Slave beat accepted when s_axis_tvalid && s_axis_tready at a rising aclk; master beat on output n transferred when m_axis_tvalid_n && m_axis_tready_n.
REQ-015 Each output SHALL own a one-entry register (data, last, valid); register n is "free" when m_axis_tvalid_n==0 or m_axis_tready_n==1.
REQ-016 Route FSM states: IDLE (no packet open; route = live sel) and LOCKED (route = route_q, captured at first beat).
REQ-017 IDLE -> LOCKED on accepted beat with s_axis_tlast==0, route_q <= sel; LOCKED -> IDLE on accepted beat with s_axis_tlast==1; single-beat packet (tlast==1 in IDLE) SHALL remain IDLE.
REQ-018 sel changes while LOCKED SHALL be ignored until the packet's tlast beat is accepted.
REQ-019 s_axis_tready SHALL equal "register of current route is free" (combinational on m_axis_tready_n); it SHALL NOT depend on the non-selected output.
REQ-020 Accepted beat SHALL load the current route's register; m_axis_tvalid_n asserts the cycle after acceptance (latency 1); full throughput of one beat per cycle when downstream ready stays high.
REQ-021 Register n SHALL clear valid after its master transfer unless reloaded in the same cycle; simultaneous drain and load SHALL present the new beat without a bubble.
REQ-022 Non-selected output SHALL hold its pending beat stable (data, last, valid) until its own transfer; both outputs may transfer in the same cycle.
REQ-023 m_axis_tdata_n / m_axis_tlast_n SHALL NOT change while m_axis_tvalid_n==1 and m_axis_tready_n==0.
REQ-024 pkt_cnt_n SHALL increment by 1 on each master transfer on output n with m_axis_tlast_n==1, wrapping 255 -> 0; both counters may increment in the same cycle.
REQ-025 s_axis_tvalid low mid-packet SHALL keep state LOCKED and route_q unchanged.

Reset
REQ-026 aresetn low SHALL immediately clear: m_axis_tvalid_n, m_axis_tlast_n, m_axis_tdata_n to 0, pkt_cnt_n to 0, FSM to IDLE, route_q to 0.
REQ-027 s_axis_tready SHALL be 0 while aresetn is low.
REQ-028 Reset asserted mid-packet SHALL discard any pending beats and open packet; after release the first accepted beat SHALL route by live sel.

Verification
REQ-029 sel=0, 4-beat packet A0..A3 (tlast on A3), m_axis_tready_0=1 -> A0..A3 on output 0, one per cycle, 1-cycle latency, tlast on A3, pkt_cnt_0=1, output 1 idle.
REQ-030 sel=1 at first beat, toggled to 0 at beat 2 of 3-beat packet -> all 3 beats on output 1, pkt_cnt_1=1; next packet follows new sel=0.
REQ-031 Route 0, m_axis_tready_0=0 with beat pending -> s_axis_tready=0, m_axis_tdata_0 stable; m_axis_tready_1 toggling has no effect; release tready_0 -> flow resumes without loss or duplication.
REQ-032 Pending beat held on output 1 (tready_1=0), new packet with sel=0 -> output 0 streams at full rate while output 1 beat stays stable.
REQ-033 256 single-beat packets to output 0 -> pkt_cnt_0 wraps to 0.
REQ-034 aresetn pulsed low mid-packet with beats pending on both outputs -> all valids 0, counters 0 immediately; post-release packet routed by current sel.
